// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int MAX_NREQ      = 8;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int IDW           = $clog2(DEF_NREQ);
    localparam int CNTW          = $clog2(DEF_MAX_BURST + 1);

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t IDLE  = 1'b0;
    localparam arb_state_t GRANT = 1'b1;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Rotate so that last+1 sits at bit 0, take the lowest set bit, map it back.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                      input logic [2:0]          last,
                                      input int                  nreq);
        logic [MAX_NREQ-1:0] rot;
        pick_t               p;
        int                  base;
        rot  = '0;
        p    = '0;
        base = (int'(last) + 1) % nreq;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (i < nreq) rot[3'(i)] = req[3'((base + i) % nreq)];
        end
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (rot[3'(i)]) begin
                p.found = 1'b1;
                p.idx   = 3'((base + i) % nreq);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the requester after 'last' has top priority,
// 'last' itself is searched last.
module rr_arbiter import fifo_arb_pkg::*; #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [MAX_NREQ-1:0] req_ext;
    pick_t               pick;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
        pick               = rr_pick(req_ext, 3'(last), NREQ);
    end

    assign found = pick.found;
    assign idx   = IW'(pick.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the asynch_fifo write port among NREQ requesters.
// Define FIFO_WR_ARB_TAG_EN to prepend the owner index to o_wdata.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter  int NREQ      = 4,
    parameter  int DSIZE     = 8,
    parameter  int MAX_BURST = 4,
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int WDW       = DSIZE + $clog2(NREQ)
`else
    localparam int WDW       = DSIZE
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*DSIZE-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_busy,
    input  logic                  i_wfull,
    output logic                  o_wr,
    output logic [WDW-1:0]        o_wdata
);

    localparam int                ID_W      = $clog2(NREQ);
    localparam int                BCNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(NREQ - 1);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   last, last_nxt, arb_last, win_idx;
    logic [BCNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic              win_found, owner_valid, beat, release_burst;
    logic [DSIZE-1:0]  req_data_arr [NREQ];
    logic [DSIZE-1:0]  owner_data;

    for (genvar k = 0; k < NREQ; k++) begin : g_data
        assign req_data_arr[k] = i_req_data[k*DSIZE +: DSIZE];
    end

    assign owner_valid = i_req_valid[owner];
    assign owner_data  = req_data_arr[owner];

    // A beat in the reset cycle is suppressed so an abandoned burst never reaches the FIFO.
    assign beat          = (state == GRANT) && owner_valid && !i_wfull && !i_rst;
    assign release_burst = (state == GRANT) && (!owner_valid || (beat && beat_cnt == LAST_BEAT));

    // On release the outgoing owner becomes 'last' in the same cycle, so the
    // next winner is found without an IDLE bubble.
    assign arb_last = release_burst ? owner : last;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (i_req_valid),
        .last  (arb_last),
        .found (win_found),
        .idx   (win_idx)
    );

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt    = GRANT;
                    owner_nxt    = win_idx;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (release_burst) begin
                    last_nxt     = owner;
                    beat_cnt_nxt = '0;
                    if (win_found) owner_nxt = win_idx;
                    else           state_nxt = IDLE;
                end else if (beat) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= LAST_INIT;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        o_grant     = '0;
        o_req_ready = '0;
        if (state == GRANT) begin
            o_grant[owner]     = 1'b1;
            o_req_ready[owner] = !i_wfull && !i_rst;
        end
    end

    assign o_busy = (state == GRANT);
    assign o_wr   = beat;

`ifdef FIFO_WR_ARB_TAG_EN
    assign o_wdata = (state == GRANT) ? {owner, owner_data} : '0;
`else
    assign o_wdata = (state == GRANT) ? owner_data : '0;
`endif

endmodule
